mem_access_initiator: RTL and testbench
=======================================

Name: mem_access_initiator

Overview:
Requesting side of the data-memory interface served by the byte-lane BRAM addresser. It takes one load/store per handshake from the CPU MEM stage and produces the addresser's memory_access_code, address and lane-aligned store data. It waits out the BRAM read latency, then returns sign- or zero-extended load data, or a store acknowledgement, to the writeback stage. Misaligned, out-of-range and illegal requests are faulted without touching memory.

Parameters:
READ_LATENCY, 1, number of clock edges from the BRAM sampling the address to valid writeback_register_data (1..4).
MEM_BYTES, 16384, addressable bytes (4 lanes x 4k); any access touching an address at or above this value faults.

Ports:
CLOCK_50  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
req_valid  in  1  MEM stage presents a request.
req_ready  out  1  block can accept; high only in IDLE.
req_is_store  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu (u codes are loads only).
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified.
req_rd  in  5  load destination register.
mem_access_code  out  5  [4] store-not-load, [3:0] byte_enable; to the addresser.
mem_address  out  32  {req_addr[31:2],2'b00}.
mem_data_to_store  out  32  lane-shifted store data.
mem_rdata  in  32  addresser writeback_register_data.
resp_valid  out  1  one-cycle response pulse.
resp_rdata  out  32  extended load data; 0 for stores and faults.
resp_rd  out  5  echoed req_rd; 0 for stores.
resp_fault  out  1  request rejected, no memory access made.
busy  out  1  inverse of req_ready; stalls the pipeline.

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1; busy=0.
- Accept: on an edge with req_valid && req_ready, register all req_* fields. Requests while busy are ignored and must be held by the MEM stage.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE on accept. IDLE -> RESP directly on accept of a faulting request.
- ISSUE: the only state in which mem_access_code is nonzero. Store: ISSUE -> RESP; the write commits at the edge that ends ISSUE. Load: ISSUE -> WAIT.
- WAIT: a counter runs READ_LATENCY cycles. On the last WAIT edge, mem_rdata is extracted and registered. WAIT -> RESP.
- RESP: resp_valid=1 for exactly one cycle; RESP -> IDLE.
- Timing, counting accept edge as t0: store resp_valid is high during t1..t2; load resp_valid is high during t(1+READ_LATENCY)..t(2+READ_LATENCY); fault resp_valid is high during t0..t1.
- mem_address holds from ISSUE through RESP and returns to 0 in IDLE. mem_data_to_store is nonzero only during a store ISSUE.
- Lane rules: L = addr[1:0].
  - Byte: byte_enable = 0001<<L; store data = wdata[7:0]<<8L; load takes rdata[8L+:8].
  - Half: byte_enable = 0011<<(2*addr[1]); store data = wdata[15:0]<<16*addr[1]; load takes rdata[16*addr[1]+:16].
  - Word: byte_enable = 1111; data passes through unchanged.
- Extension: b and h sign-extend; bu and hu zero-extend.
- Faults, all giving resp_fault=1, resp_rdata=0 and no ISSUE:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - any access with addr+size > MEM_BYTES;
  - funct3 011, 110 or 111;
  - store with funct3[2]=1.
- Reset mid-operation: the next edge forces IDLE, and the in-flight response is dropped (resp_valid never pulses for it). A store already presented during ISSUE at the reset edge is still sampled by the BRAMs; this block does not cancel it.
- Arithmetic: the range check uses 33-bit addition so wrap near 2^32 faults.

Decomposition:
- Package mem_access_pkg: funct3 constants, access-code bit positions (STORE_BIT=4, BE_MSB=3), FSM state encoding, size-from-funct3 function.
- Sub-module mem_lane_align: combinational byte-enable generation, store shift and load extract/extend, so the same logic can be unit-tested and reused by a future DMA port.

Test Plan:
1. Reset held 2 cycles, then released -> req_ready=1, every other output 0, mem_access_code=5'b0_0000.
2. sw addr 0, wdata F0F1F2F3 -> during ISSUE code 1_1111, mem_address 0, data F0F1F2F3; resp_valid at t1, resp_fault 0, resp_rdata 0.
3. sb addr 5, wdata 000000A5 -> code 1_0010, mem_address 4, data 0000A500. sh addr 6, wdata 0000BEEF -> code 1_1100, data BEEF0000.
4. Loads with mem_rdata=F0F1F2F3, READ_LATENCY=1:
   - lb addr 1 -> FFFFFFF2;
   - lbu addr 1 -> 000000F2;
   - lh addr 2 -> FFFFF0F1;
   - lw addr 0 -> F0F1F2F3.
   Each resp_valid at t2, resp_rd echoed; repeat with READ_LATENCY=3 -> resp_valid at t4.
5. Faults: lw addr 2, sh addr 3, lw addr 16384, load funct3 011 -> resp_valid at t0 with resp_fault=1; mem_access_code stays 0 throughout.
6. req_valid held high while busy -> exactly one accept per request. Reset asserted during WAIT -> IDLE next cycle, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory requester: width codes, access-code
// layout, FSM encoding, the registered request record and the size helper.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // memory_access_code layout: [STORE_BIT] store-not-load, [BE_MSB:0] byte enables
  localparam int STORE_BIT = 4;
  localparam int BE_MSB    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Everything captured at the accept edge; fault is resolved up front so the
  // FSM never has to look at the raw request again.
  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        fault;
  } req_t;

  // Bytes touched by an access; 0 marks an illegal width code.
  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_size = 3'd1;
      F3_H, F3_HU: access_size = 3'd2;
      F3_W:        access_size = 3'd4;
      default:     access_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store-data lane shift and
// load-data extract with sign/zero extension. Assumes an aligned request.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [31:0] rsh;

  // Pick lanes by width code; the selected lane is shifted down to bit 0 for loads.
  always_comb begin
    byte_en    = 4'b0000;
    store_data = 32'h0;
    load_data  = 32'h0;
    rsh        = 32'h0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en    = 4'b0001 << addr_lo;
        store_data = {24'h0, wdata[7:0]} << {addr_lo, 3'b000};
        rsh        = rdata >> {addr_lo, 3'b000};
        load_data  = (funct3 == F3_B) ? {{24{rsh[7]}}, rsh[7:0]} : {24'h0, rsh[7:0]};
      end
      F3_H, F3_HU: begin
        byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
        store_data = {16'h0, wdata[15:0]} << {addr_lo[1], 4'b0000};
        rsh        = rdata >> {addr_lo[1], 4'b0000};
        load_data  = (funct3 == F3_H) ? {{16{rsh[15]}}, rsh[15:0]} : {16'h0, rsh[15:0]};
      end
      F3_W: begin
        byte_en    = 4'b1111;
        store_data = wdata;
        load_data  = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_initiator.sv
// Data-memory requester: accepts one load/store from the MEM stage, drives the
// BRAM addresser for one ISSUE cycle, waits out read latency and returns a
// single-cycle response. Faulting requests never reach memory.
module mem_access_initiator
  import mem_access_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int MEM_BYTES    = 16384
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [4:0]  mem_access_code,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_to_store,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_fault,
  output logic        busy
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
  localparam logic [2:0]  CNT_LAST  = 3'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  req_t        req_q;
  logic [2:0]  cnt_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        in_fault;
  logic [32:0] end_addr;
  logic        wait_last;
  logic [3:0]  byte_en;
  logic [31:0] store_data;
  logic [31:0] load_data;

  assign accept    = req_valid && (state_q == ST_IDLE);
  assign wait_last = (cnt_q == CNT_LAST);

  // Classify the incoming request; 33-bit end address so wrap past 2^32 faults.
  always_comb begin
    end_addr = {1'b0, req_addr} + {30'h0, access_size(req_funct3)};
    in_fault = 1'b0;
    if (access_size(req_funct3) == 3'd0)                           in_fault = 1'b1;
    if (req_is_store && req_funct3[2])                             in_fault = 1'b1;
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])                 in_fault = 1'b1;
    if ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00))          in_fault = 1'b1;
    if (end_addr > MEM_LIMIT)                                      in_fault = 1'b1;
  end

  mem_lane_align u_align (
    .funct3     (req_q.funct3),
    .addr_lo    (req_q.addr[1:0]),
    .wdata      (req_q.wdata),
    .rdata      (mem_rdata),
    .byte_en    (byte_en),
    .store_data (store_data),
    .load_data  (load_data)
  );

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: faults jump straight to RESP; stores skip WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = in_fault ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = req_q.is_store ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (wait_last) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request capture, latency counter and load-data capture on the last WAIT edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      req_q   <= '0;
      cnt_q   <= 3'd0;
      rdata_q <= 32'h0;
    end else begin
      if (accept)
        req_q <= '{is_store: req_is_store, funct3: req_funct3, addr: req_addr,
                   wdata: req_wdata, rd: req_rd, fault: in_fault};
      if (state_q == ST_ISSUE)     cnt_q <= 3'd0;
      else if (state_q == ST_WAIT) cnt_q <= cnt_q + 3'd1;
      if ((state_q == ST_WAIT) && wait_last) rdata_q <= load_data;
    end
  end

  // Outputs decoded from state; memory strobes exist only in ISSUE.
  always_comb begin
    req_ready         = (state_q == ST_IDLE);
    busy              = (state_q != ST_IDLE);
    mem_access_code   = 5'h0;
    mem_address       = 32'h0;
    mem_data_to_store = 32'h0;
    resp_valid        = 1'b0;
    resp_rdata        = 32'h0;
    resp_rd           = 5'h0;
    resp_fault        = 1'b0;
    if ((state_q != ST_IDLE) && !req_q.fault)
      mem_address = {req_q.addr[31:2], 2'b00};
    if (state_q == ST_ISSUE) begin
      mem_access_code[STORE_BIT]  = req_q.is_store;
      mem_access_code[BE_MSB:0]   = byte_en;
      if (req_q.is_store) mem_data_to_store = store_data;
    end
    if (state_q == ST_RESP) begin
      resp_valid = 1'b1;
      resp_fault = req_q.fault;
      resp_rd    = req_q.is_store ? 5'h0 : req_q.rd;
      if (!req_q.is_store && !req_q.fault) resp_rdata = rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench: two instances (READ_LATENCY 1 and 3) share the request bus;
// each transaction is watched for 7 cycles after its accept edge.
module tb_mem_access_initiator;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'h0;
  logic [31:0] mem_rdata = 32'hF0F1F2F3;

  logic        rdy_a, rv_a, flt_a, busy_a;
  logic [4:0]  code_a, rd_a;
  logic [31:0] addr_a, dts_a, rdata_a;
  logic        rdy_b, rv_b, flt_b, busy_b;
  logic [4:0]  code_b, rd_b;
  logic [31:0] addr_b, dts_b, rdata_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  mem_access_initiator #(.READ_LATENCY(1)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .req_valid(req_valid), .req_ready(rdy_a),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_access_code(code_a),
    .mem_address(addr_a), .mem_data_to_store(dts_a), .mem_rdata(mem_rdata),
    .resp_valid(rv_a), .resp_rdata(rdata_a), .resp_rd(rd_a), .resp_fault(flt_a),
    .busy(busy_a));

  mem_access_initiator #(.READ_LATENCY(3)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .req_valid(req_valid), .req_ready(rdy_b),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_access_code(code_b),
    .mem_address(addr_b), .mem_data_to_store(dts_b), .mem_rdata(mem_rdata),
    .resp_valid(rv_b), .resp_rdata(rdata_b), .resp_rd(rd_b), .resp_fault(flt_b),
    .busy(busy_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One request; k counts negedges after the accept edge (k=0 is the t0..t1 cycle).
  task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic [4:0] e_code,
                         input logic [31:0] e_addr, input logic [31:0] e_data,
                         input logic [31:0] e_rdata, input logic e_fault);
    int ka, kb, na, nb, ea, eb;
    logic [4:0]  c0, cor, rda;
    logic [31:0] a0, d0, ra, rb;
    logic        fa, fb;
    ka = -1; kb = -1; na = 0; nb = 0; cor = 5'h0; c0 = 5'h0; rda = 5'h0;
    a0 = 32'h0; d0 = 32'h0; ra = 32'h0; rb = 32'h0; fa = 1'b0; fb = 1'b0;
    @(negedge CLOCK_50);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge CLOCK_50);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge CLOCK_50);
      cor |= code_a;
      if (k == 0) begin c0 = code_a; a0 = addr_a; d0 = dts_a; end
      if (rv_a) begin
        na++;
        if (ka < 0) begin ka = k; ra = rdata_a; fa = flt_a; rda = rd_a; end
      end
      if (rv_b) begin
        nb++;
        if (kb < 0) begin kb = k; rb = rdata_b; fb = flt_b; end
      end
    end
    ea = e_fault ? 0 : (st ? 1 : 2);
    eb = e_fault ? 0 : (st ? 1 : 4);
    chk({tag, ".code"},    {27'h0, c0}, {27'h0, e_code});
    chk({tag, ".code_or"}, {27'h0, cor}, {27'h0, e_code});
    chk({tag, ".wdata"},   d0, e_data);
    if (!e_fault) begin
      chk({tag, ".addr"}, a0, e_addr);
      chk({tag, ".rd"},   {27'h0, rda}, st ? 32'h0 : {27'h0, rd});
    end
    chk({tag, ".t_a"},     ka, ea);
    chk({tag, ".t_b"},     kb, eb);
    chk({tag, ".n_a"},     na, 1);
    chk({tag, ".n_b"},     nb, 1);
    chk({tag, ".rdata_a"}, ra, e_rdata);
    chk({tag, ".rdata_b"}, rb, e_rdata);
    chk({tag, ".fault_a"}, {31'h0, fa}, {31'h0, e_fault});
    chk({tag, ".fault_b"}, {31'h0, fb}, {31'h0, e_fault});
    chk({tag, ".addr_idle"}, addr_a, 32'h0);
  endtask

  initial begin
    int acc, nresp, nra, nrb;
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    @(negedge CLOCK_50);
    chk("rst.ready", {31'h0, rdy_a}, 32'h1);
    chk("rst.busy",  {31'h0, busy_a}, 32'h0);
    chk("rst.code",  {27'h0, code_a}, 32'h0);
    chk("rst.addr",  addr_a, 32'h0);
    chk("rst.dts",   dts_a, 32'h0);
    chk("rst.resp",  {26'h0, rv_a, flt_a, rd_a}, 32'h0);
    chk("rst.rdata", rdata_a, 32'h0);

    // stores
    run_req("sw0",  1'b1, 3'b010, 32'd0, 32'hF0F1F2F3, 5'd3, 5'h1F, 32'd0, 32'hF0F1F2F3, 32'h0, 1'b0);
    run_req("sb5",  1'b1, 3'b000, 32'd5, 32'h000000A5, 5'd3, 5'h12, 32'd4, 32'h0000A500, 32'h0, 1'b0);
    run_req("sh6",  1'b1, 3'b001, 32'd6, 32'h0000BEEF, 5'd3, 5'h1C, 32'd4, 32'hBEEF0000, 32'h0, 1'b0);
    // loads against F0F1F2F3
    run_req("lb1",  1'b0, 3'b000, 32'd1, 32'h0, 5'd10, 5'h02, 32'd0, 32'h0, 32'hFFFFFFF2, 1'b0);
    run_req("lbu1", 1'b0, 3'b100, 32'd1, 32'h0, 5'd11, 5'h02, 32'd0, 32'h0, 32'h000000F2, 1'b0);
    run_req("lh2",  1'b0, 3'b001, 32'd2, 32'h0, 5'd12, 5'h0C, 32'd0, 32'h0, 32'hFFFFF0F1, 1'b0);
    run_req("lhu2", 1'b0, 3'b101, 32'd2, 32'h0, 5'd14, 5'h0C, 32'd0, 32'h0, 32'h0000F0F1, 1'b0);
    run_req("lw0",  1'b0, 3'b010, 32'd0, 32'h0, 5'd13, 5'h0F, 32'd0, 32'h0, 32'hF0F1F2F3, 1'b0);
    // top-of-memory boundaries that must still succeed
    run_req("lwtop", 1'b0, 3'b010, 32'd16380, 32'h0, 5'd15, 5'h0F, 32'h3FFC, 32'h0, 32'hF0F1F2F3, 1'b0);
    run_req("lbend", 1'b0, 3'b000, 32'd16383, 32'h0, 5'd16, 5'h08, 32'h3FFC, 32'h0, 32'hFFFFFFF0, 1'b0);
    // faults
    run_req("flw2",   1'b0, 3'b010, 32'd2,        32'h0,    5'd1, 5'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    run_req("fsh3",   1'b1, 3'b001, 32'd3,        32'h1234, 5'd1, 5'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    run_req("flw16k", 1'b0, 3'b010, 32'd16384,    32'h0,    5'd1, 5'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    run_req("ff3",    1'b0, 3'b011, 32'd0,        32'h0,    5'd1, 5'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    run_req("fsbu",   1'b1, 3'b100, 32'd0,        32'h55,   5'd1, 5'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    run_req("fwrap",  1'b0, 3'b000, 32'hFFFFFFFF, 32'h0,    5'd1, 5'h0, 32'h0, 32'h0, 32'h0, 1'b1);

    // req_valid held while busy: one accept, one response
    acc = 0; nresp = 0;
    @(negedge CLOCK_50);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'd4; req_rd = 5'd7;
    for (int k = 0; k < 8; k++) begin
      if (req_valid && rdy_a) acc++;
      @(negedge CLOCK_50);
      if (rv_a) begin nresp++; req_valid = 1'b0; end
    end
    req_valid = 1'b0;
    chk("hold.accepts", acc, 1);
    chk("hold.resps", nresp, 1);
    repeat (4) @(negedge CLOCK_50);

    // reset while both instances sit in WAIT: response dropped
    nra = 0; nrb = 0;
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'd8; req_rd = 5'd9;
    @(posedge CLOCK_50);
    #1 req_valid = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rstw.busy", {31'h0, busy_a}, 32'h1);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
    @(negedge CLOCK_50);
    chk("rstw.ready_a", {31'h0, rdy_a}, 32'h1);
    chk("rstw.ready_b", {31'h0, rdy_b}, 32'h1);
    for (int k = 0; k < 6; k++) begin
      if (rv_a) nra++;
      if (rv_b) nrb++;
      @(negedge CLOCK_50);
    end
    chk("rstw.resp_a", nra, 0);
    chk("rstw.resp_b", nrb, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
